cipher_sched: RTL and testbench



---
 rtl/cipher_pkg.sv | 21 ++
 rtl/rr_arbiter3.sv | 26 ++
 rtl/cipher_sched.sv | 166 ++++++++++++++++
 tb/tb_cipher_sched.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
// Shared encodings and scheduler state type for the cipher_sched slice.
package cipher_pkg;

    localparam int unsigned NUM_CIPHERS = 3;

    localparam logic [1:0] CIPHER_CAESAR  = 2'd0;
    localparam logic [1:0] CIPHER_SCYTALE = 2'd1;
    localparam logic [1:0] CIPHER_ZIGZAG  = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        XFER,
        DRAIN
    } sched_state_t;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx >= CIPHER_ZIGZAG) ? CIPHER_CAESAR : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational round-robin pick over three requesters, searching upward from ptr_i with wrap.
module rr_arbiter3
    import cipher_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [1:0] gnt_o,
    output logic       found_o
);

    logic [1:0] idx;

    always_comb begin
        gnt_o   = '0;
        found_o = 1'b0;
        idx     = ptr_i;
        for (int unsigned i = 0; i < NUM_CIPHERS; i++) begin
            if (!found_o && req_i[idx]) begin
                gnt_o   = idx;
                found_o = 1'b1;
            end
            idx = next_idx(idx);
        end
    end

endmodule

// File: rtl/cipher_sched.sv
// Round-robin message scheduler in front of the cipher demux; paces words and drains engines.
// Optional per-requester message counters are enabled with CIPHER_SCHED_STATS_EN.
module cipher_sched
    import cipher_pkg::*;
#(
    parameter int unsigned MST_DWIDTH = 32,
    parameter int unsigned BEAT_GAP   = 4,
    parameter int unsigned MAX_WORDS  = 16
) (
    input  logic                    clk_sys,
    input  logic                    rst,
    input  logic [3*MST_DWIDTH-1:0] data_i,
    input  logic [2:0]              valid_i,
    input  logic [2:0]              last_i,
    output logic [2:0]              ready_o,
    input  logic [2:0]              busy_i,
    output logic [MST_DWIDTH-1:0]   data_o,
    output logic                    valid_o,
    output logic [1:0]              select_o,
    output logic                    err_o
`ifdef CIPHER_SCHED_STATS_EN
    ,
    output logic [15:0]             msg_cnt0_o,
    output logic [15:0]             msg_cnt1_o,
    output logic [15:0]             msg_cnt2_o
`endif
);

    localparam int unsigned WCNT_W = $clog2(MAX_WORDS + 1);
    localparam int unsigned GAP_W  = (BEAT_GAP > 1) ? $clog2(BEAT_GAP) : 1;
    localparam logic [GAP_W-1:0]  GAP_RELOAD = GAP_W'(BEAT_GAP - 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX   = WCNT_W'(MAX_WORDS);

    sched_state_t          state_q, state_d;
    logic [1:0]            gnt_q, gnt_d;
    logic [1:0]            rr_ptr_q, rr_ptr_d;
    logic [WCNT_W-1:0]     word_cnt_q, word_cnt_d, word_cnt_inc;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic [MST_DWIDTH-1:0] data_q, data_d, word_in;
    logic                  valid_q, valid_d;
    logic [1:0]            select_q, select_d;
    logic                  err_q, err_d;
    logic                  drain_done;
    logic [1:0]            arb_gnt;
    logic                  arb_found;

    rr_arbiter3 u_arb (
        .req_i   (valid_i),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (arb_gnt),
        .found_o (arb_found)
    );

    assign word_in      = data_i[gnt_q*MST_DWIDTH +: MST_DWIDTH];
    assign word_cnt_inc = word_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        word_cnt_d = word_cnt_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        select_d   = select_q;
        err_d      = 1'b0;
        ready_o    = '0;
        drain_done = 1'b0;
        // The pacing counter runs freely so gaps keep elapsing while the requester idles.
        gap_cnt_d  = (gap_cnt_q != '0) ? gap_cnt_q - 1'b1 : gap_cnt_q;

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    gnt_d    = arb_gnt;
                    select_d = arb_gnt;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (!busy_i[gnt_q]) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (gap_cnt_q == '0) begin
                    ready_o[gnt_q] = 1'b1;
                    if (valid_i[gnt_q]) begin
                        data_d     = word_in;
                        valid_d    = 1'b1;
                        word_cnt_d = word_cnt_inc;
                        gap_cnt_d  = GAP_RELOAD;
                        if (last_i[gnt_q]) begin
                            state_d = DRAIN;
                        end else if (word_cnt_inc == WCNT_MAX) begin
                            err_d   = 1'b1;
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                drain_done = (gap_cnt_q == '0) && !busy_i[gnt_q];
                if (drain_done) begin
                    rr_ptr_d   = next_idx(gnt_q);
                    word_cnt_d = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= CIPHER_CAESAR;
            rr_ptr_q   <= CIPHER_CAESAR;
            word_cnt_q <= '0;
            gap_cnt_q  <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            select_q   <= CIPHER_CAESAR;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            word_cnt_q <= word_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            select_q   <= select_d;
            err_q      <= err_d;
        end
    end

    assign data_o   = data_q;
    assign valid_o  = valid_q;
    assign select_o = select_q;
    assign err_o    = err_q;

`ifdef CIPHER_SCHED_STATS_EN
    logic [15:0] msg_cnt_q [NUM_CIPHERS];
    logic [15:0] msg_cnt_d [NUM_CIPHERS];

    always_comb begin
        msg_cnt_d = msg_cnt_q;
        if (drain_done) begin
            msg_cnt_d[gnt_q] = msg_cnt_q[gnt_q] + 16'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            msg_cnt_q <= '{default: '0};
        end else begin
            msg_cnt_q <= msg_cnt_d;
        end
    end

    assign msg_cnt0_o = msg_cnt_q[0];
    assign msg_cnt1_o = msg_cnt_q[1];
    assign msg_cnt2_o = msg_cnt_q[2];
`endif

endmodule

// File: tb/tb_cipher_sched.sv
// Self-checking bench for cipher_sched: message-level reference model plus directed timing pins.
module tb_cipher_sched;

    localparam int DW   = 32;
    localparam int GAP  = 4;
    localparam int MAXW = 16;

    logic          clk_sys = 1'b0;
    logic          rst;
    logic [3*DW-1:0] data_i;
    logic [2:0]    valid_i, last_i, busy_i;
    logic [2:0]    ready_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic [1:0]    select_o;
    logic          err_o;
`ifdef CIPHER_SCHED_STATS_EN
    logic [15:0]   msg_cnt0_o, msg_cnt1_o, msg_cnt2_o;
`endif

    always #5 clk_sys = ~clk_sys;

    cipher_sched #(
        .MST_DWIDTH (DW),
        .BEAT_GAP   (GAP),
        .MAX_WORDS  (MAXW)
    ) dut (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .last_i   (last_i),
        .ready_o  (ready_o),
        .busy_i   (busy_i),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .select_o (select_o),
        .err_o    (err_o)
`ifdef CIPHER_SCHED_STATS_EN
        ,
        .msg_cnt0_o (msg_cnt0_o),
        .msg_cnt1_o (msg_cnt1_o),
        .msg_cnt2_o (msg_cnt2_o)
`endif
    );

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Requester-side message queues; words leave only when the model accepts them.
    logic [31:0] q_w [3][$];
    bit          q_l [3][$];

    // Reference model: who owns the demux, and from which cycle the next word may be taken.
    int          m_owner = -1;
    bit          m_settled, m_done;
    int          m_sent, m_next_ok, m_rr;
    bit          exp_valid, exp_err;
    logic [31:0] exp_data;
    logic [1:0]  exp_sel;
    logic [15:0] exp_cnt [3];

    int          log_cyc [$];
    logic [31:0] log_dat [$];
    int          err_log [$];

    function automatic logic [2:0] model_ready();
        logic [2:0] r;
        r = '0;
        if (m_owner >= 0 && m_settled && !m_done && cyc >= m_next_ok) r[m_owner] = 1'b1;
        return r;
    endfunction

    always @(posedge clk_sys) begin : model
        logic [2:0] rdy;
        bit         lst;
        int         k;
        rdy       = model_ready();
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (rst) begin
            m_owner  = -1;
            m_rr     = 0;
            exp_data = '0;
            exp_sel  = '0;
            for (int j = 0; j < 3; j++) begin
                q_w[j].delete();
                q_l[j].delete();
                exp_cnt[j] = '0;
            end
        end else if (m_owner < 0) begin
            for (int i = 0; i < 3; i++) begin
                k = (m_rr + i) % 3;
                if (m_owner < 0 && valid_i[k]) m_owner = k;
            end
            if (m_owner >= 0) begin
                exp_sel   = 2'(m_owner);
                m_settled = 1'b0;
                m_done    = 1'b0;
                m_sent    = 0;
                m_next_ok = 0;
            end
        end else if (!m_settled) begin
            if (!busy_i[m_owner]) m_settled = 1'b1;
        end else if (!m_done) begin
            if (rdy[m_owner] && valid_i[m_owner]) begin
                exp_valid = 1'b1;
                exp_data  = q_w[m_owner].pop_front();
                lst       = q_l[m_owner].pop_front();
                m_sent++;
                m_next_ok = cyc + GAP;
                if (lst) m_done = 1'b1;
                else if (m_sent == MAXW) begin
                    exp_err = 1'b1;
                    m_done  = 1'b1;
                end
            end
        end else if (cyc >= m_next_ok && !busy_i[m_owner]) begin
            exp_cnt[m_owner] = exp_cnt[m_owner] + 16'd1;
            m_rr    = (m_owner + 1) % 3;
            m_owner = -1;
        end
        cyc++;
    end

    always @(negedge clk_sys) begin
        if (cmp_en) begin
            check("valid_o", 32'(valid_o), 32'(exp_valid));
            check("data_o", data_o, exp_data);
            check("select_o", 32'(select_o), 32'(exp_sel));
            check("ready_o", 32'(ready_o), 32'(model_ready()));
            check("err_o", 32'(err_o), 32'(exp_err));
`ifdef CIPHER_SCHED_STATS_EN
            check("msg_cnt0_o", 32'(msg_cnt0_o), 32'(exp_cnt[0]));
            check("msg_cnt1_o", 32'(msg_cnt1_o), 32'(exp_cnt[1]));
            check("msg_cnt2_o", 32'(msg_cnt2_o), 32'(exp_cnt[2]));
`endif
            if (valid_o) begin
                log_cyc.push_back(cyc);
                log_dat.push_back(data_o);
            end
            if (err_o) err_log.push_back(cyc);
        end
    end

    task automatic drive();
        for (int k = 0; k < 3; k++) begin
            if (q_w[k].size() > 0) begin
                valid_i[k]           = 1'b1;
                data_i[k*DW +: DW]   = q_w[k][0];
                last_i[k]            = q_l[k][0];
            end else begin
                valid_i[k]           = 1'b0;
                data_i[k*DW +: DW]   = '0;
                last_i[k]            = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
        drive();
    endtask

    task automatic push_msg(input int k, input int n, input logic [31:0] base, input bit with_last);
        for (int i = 0; i < n; i++) begin
            q_w[k].push_back(base + 32'(i));
            q_l[k].push_back(with_last && (i == n - 1));
        end
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        log_cyc.delete();
        log_dat.delete();
        err_log.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((q_w[0].size() + q_w[1].size() + q_w[2].size() > 0 || m_owner >= 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check("idle_timeout", 32'(n), 32'(0));
        repeat (3) tick();
    endtask

    initial begin
        int s;
        int n;
        int cnt0;
        rst     = 1'b1;
        valid_i = '0;
        last_i  = '0;
        busy_i  = '0;
        data_i  = '0;
        repeat (3) tick();
        cmp_en = 1'b1;
        rst    = 1'b0;
        repeat (20) tick();
        check("idle_ready", 32'(ready_o), 32'(0));
        check("idle_valid", 32'(valid_o), 32'(0));

        // Requester 1, three words, beats 4 cycles apart.
        do_reset();
        s = cyc;
        q_w[1].push_back(32'hA1A2A3A4); q_l[1].push_back(1'b0);
        q_w[1].push_back(32'hB1B2B3B4); q_l[1].push_back(1'b0);
        q_w[1].push_back(32'hC1C2C3C4); q_l[1].push_back(1'b1);
        drive();
        tick();
        check("sel_after_req", 32'(select_o), 32'(1));
        wait_idle(100);
        check("r1_beats", 32'(log_cyc.size()), 32'(3));
        if (log_cyc.size() == 3) begin
            check("r1_w0", log_dat[0], 32'hA1A2A3A4);
            check("r1_w1", log_dat[1], 32'hB1B2B3B4);
            check("r1_w2", log_dat[2], 32'hC1C2C3C4);
            for (int i = 0; i < 3; i++) check("r1_beat_time", 32'(log_cyc[i] - s), 32'(3 + 4 * i));
        end

        // All three requesting: grants rotate 0,1,2,0,1,2.
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int m = 0; m < 2; m++) push_msg(r, 1, 32'(r * 16 + m), 1'b1);
        wait_idle(200);
        check("rr_beats", 32'(log_dat.size()), 32'(6));
        if (log_dat.size() == 6)
            for (int i = 0; i < 6; i++) check("rr_order", log_dat[i], 32'((i % 3) * 16 + i / 3));

        // Engine 2 busy through GRANT for 10 cycles.
        do_reset();
        busy_i = 3'b100;
        s = cyc;
        push_msg(2, 1, 32'h2222_0000, 1'b1);
        repeat (10) tick();
        busy_i = 3'b000;
        wait_idle(100);
        check("busy_grant_beat", 32'(log_cyc.size() > 0 ? log_cyc[0] - s : -1), 32'(12));

        // Engine 2 busy through DRAIN delays the re-grant.
        do_reset();
        s = cyc;
        push_msg(2, 1, 32'h2222_0001, 1'b1);
        push_msg(2, 1, 32'h2222_0002, 1'b1);
        repeat (3) tick();
        busy_i = 3'b100;
        repeat (10) tick();
        busy_i = 3'b000;
        wait_idle(100);
        check("busy_drain_n", 32'(log_cyc.size()), 32'(2));
        if (log_cyc.size() == 2) begin
            check("busy_drain_b0", 32'(log_cyc[0] - s), 32'(3));
            check("busy_drain_b1", 32'(log_cyc[1] - s), 32'(17));
        end

        // Reset while a word is being accepted: nothing emerges.
        do_reset();
        push_msg(0, 3, 32'h0000_5000, 1'b1);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_valid", 32'(valid_o), 32'(0));
        check("rst_mid_ready", 32'(ready_o), 32'(0));
        check("rst_mid_sel", 32'(select_o), 32'(0));
        rst = 1'b0;
        repeat (3) tick();

        // Overrun: 17 words without last from requester 0, then requester 1 gets its turn.
        do_reset();
        push_msg(0, 17, 32'h0F00_0000, 1'b0);
        push_msg(1, 1, 32'h1111_0000, 1'b1);
        n = 0;
        while ((q_w[1].size() > 0 || m_owner >= 0) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) check("ovr_timeout", 32'(n), 32'(0));
        repeat (3) tick();
        cnt0 = 0;
        foreach (log_dat[i]) if (log_dat[i][31:24] == 8'h0F) cnt0++;
        check("ovr_words", 32'(cnt0), 32'(16));
        check("ovr_err_pulses", 32'(err_log.size()), 32'(1));
        if (log_dat.size() == 17) begin
            check("ovr_next_grant", log_dat[16], 32'h1111_0000);
            check("ovr_err_time", 32'(err_log.size() > 0 ? err_log[0] : -1), 32'(log_cyc[15]));
        end else check("ovr_total", 32'(log_dat.size()), 32'(17));

        // Randomised traffic with random engine busy.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (q_w[k].size() < 8 && $urandom_range(0, 19) == 0) begin
                    if ($urandom_range(0, 9) == 0) push_msg(k, 17, $urandom, 1'b1);
                    else push_msg(k, int'($urandom_range(1, 5)), $urandom, 1'b1);
                end
                if ($urandom_range(0, 9) == 0) busy_i[k] = ~busy_i[k];
            end
            tick();
        end
        busy_i = 3'b000;
        wait_idle(3000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
